// File: rtl/dsp_alu_pkg.sv
// Shared widths, FSM state type and saturating add for the accumulate ALU.
// The saturating add is used only when DSP_ALU_SATURATE_EN is defined.
package dsp_alu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ACC
  } state_e;

  function automatic logic [DATA_W-1:0] sat_add(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] s;
    s = a + b;
    // Same-sign operands with a flipped result sign overflowed.
    if ((a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]))
      s = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                      : {1'b0, {(DATA_W-1){1'b1}}};
    return s;
  endfunction

endpackage

// File: rtl/dsp_alu_ram_mem.sv
// 64x16 single-port RAM, synchronous read-first, 1-cycle read latency.
// Only the read register is reset; the array keeps its contents.
module dsp_alu_ram_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout <= '0;
    else     dout <= mem[addr];
  end

endmodule

// File: rtl/dsp_alu_ram.sv
// Data RAM plus accumulate sequencer: sums len words from base, pulses done.
// Define DSP_ALU_SATURATE_EN for signed saturating accumulation.
module dsp_alu_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              c,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] rdata
);

  import dsp_alu_pkg::*;

  localparam logic [ADDR_W:0] REM_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] REM_FULL = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   rem_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] result_q;
  logic              done_q;
  logic [DATA_W-1:0] sum_d;
  logic              idle;
  logic [ADDR_W-1:0] sel_addr;

  assign idle     = (state_q == IDLE);
  assign sel_addr = idle ? addr : ptr_q;

  dsp_alu_ram_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk (c),
    .rst (rst),
    .we  (we & idle),
    .addr(sel_addr),
    .din (din),
    .dout(rdata)
  );

  always_comb begin
    sum_d = '0;
`ifdef DSP_ALU_SATURATE_EN
    sum_d = sat_add(acc_q, rdata);
`else
    sum_d = acc_q + rdata;
`endif
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ptr_q   <= base;
            rem_q   <= (len == '0) ? REM_FULL : {1'b0, len};
            acc_q   <= '0;
            state_q <= FETCH;
          end
        end
        FETCH: state_q <= ACC;
        ACC: begin
          if (rem_q == REM_ONE) begin
            result_q <= sum_d;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end else begin
            acc_q   <= sum_d;
            ptr_q   <= ptr_q + 1'b1;
            rem_q   <= rem_q - 1'b1;
            state_q <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = ~idle;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_dsp_alu_ram.sv
// Directed bench for dsp_alu_ram: vector table of runs plus corner sequences.
// Expected sums follow DSP_ALU_SATURATE_EN when it is defined.
module tb_dsp_alu_ram;

`ifdef DSP_ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        c;
  logic        rst;
  logic        we;
  logic [5:0]  addr;
  logic [15:0] din;
  logic        start;
  logic [5:0]  base;
  logic [5:0]  len;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] rdata;

  bit clk_en = 1'b0;
  int pass_cnt = 0;
  int tot_cnt = 0;

  dsp_alu_ram dut (
    .c     (c),
    .rst   (rst),
    .we    (we),
    .addr  (addr),
    .din   (din),
    .start (start),
    .base  (base),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .result(result),
    .rdata (rdata)
  );

  initial begin
    c = 1'b0;
    forever begin
      #5;
      if (clk_en) c = ~c;
    end
  end

  typedef struct {
    logic [5:0]  b;
    logic [5:0]  l;
    logic [15:0] ew;
    logic [15:0] es;
    int          cyc;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    @(negedge c);
    we = 1'b1; addr = a; din = d;
    @(negedge c);
    we = 1'b0;
  endtask

  task automatic run(input logic [5:0] b, input logic [5:0] l,
                     input bit intf, output int cyc, output int nd,
                     output logic [15:0] res);
    @(negedge c);
    start = 1'b1; base = b; len = l;
    @(negedge c);
    start = 1'b0;
    cyc = 0;
    nd = 0;
    while (busy && cyc < 300) begin
      cyc++;
      if (done) nd++;
      if (intf && cyc == 2) begin
        we = 1'b1; addr = 6'd2; din = 16'd99; start = 1'b1;
      end else begin
        we = 1'b0; start = 1'b0;
      end
      @(negedge c);
    end
    we = 1'b0;
    start = 1'b0;
    if (done) nd++;
    res = result;
    @(negedge c);
    if (done) nd++;
  endtask

  int          cyc;
  int          nd;
  logic [15:0] res;

  initial begin
    rst = 1'b0; we = 1'b0; start = 1'b0;
    addr = '0; din = '0; base = '0; len = '0;

    vt[0] = '{6'd0,  6'd4, 16'd10,    16'd10,    8};
    vt[1] = '{6'd63, 6'd2, 16'd6,     16'd6,     4};
    vt[2] = '{6'd10, 6'd2, 16'h8000,  16'h7FFF,  4};
    vt[3] = '{6'd20, 6'd2, 16'h7FFF,  16'h8000,  4};
    vt[4] = '{6'd30, 6'd3, 16'h7FFE,  16'hFFFF,  6};
    vt[5] = '{6'd2,  6'd1, 16'd3,     16'd3,     2};

    #1 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_rdata", rdata, 0);

    clk_en = 1'b1;
    repeat (2) @(negedge c);
    rst = 1'b0;

    wr(6'd0, 16'd1);
    wr(6'd1, 16'd2);
    wr(6'd2, 16'd3);
    wr(6'd3, 16'd4);
    wr(6'd63, 16'd5);
    wr(6'd10, 16'h7FFF);
    wr(6'd11, 16'h0001);
    wr(6'd20, 16'h8000);
    wr(6'd21, 16'hFFFF);
    wr(6'd30, 16'h7FFF);
    wr(6'd31, 16'h7FFF);
    wr(6'd32, 16'h8000);

    for (int i = 0; i < 6; i++) begin
      run(vt[i].b, vt[i].l, 1'b0, cyc, nd, res);
      chk($sformatf("vec%0d_result", i), res, SAT ? vt[i].es : vt[i].ew);
      chk($sformatf("vec%0d_cycles", i), cyc, vt[i].cyc);
      chk($sformatf("vec%0d_dones", i), nd, 1);
    end

    run(6'd0, 6'd4, 1'b1, cyc, nd, res);
    chk("intlk_result", res, 16'd10);
    chk("intlk_cycles", cyc, 8);
    chk("intlk_dones", nd, 1);
    addr = 6'd2;
    @(negedge c);
    chk("intlk_rdata", rdata, 16'd3);
    run(6'd2, 6'd1, 1'b0, cyc, nd, res);
    chk("intlk_mem2", res, 16'd3);

    @(negedge c);
    start = 1'b1; base = 6'd0; len = 6'd4;
    @(negedge c);
    start = 1'b0;
    repeat (2) @(negedge c);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_result", result, 0);
    chk("midrst_done", done, 0);
    @(negedge c);
    chk("midrst_done_hold", done, 0);
    rst = 1'b0;
    run(6'd0, 6'd4, 1'b0, cyc, nd, res);
    chk("rerun_result", res, 16'd10);
    chk("rerun_dones", nd, 1);

    wr(6'd63, 16'd5);
    wr(6'd0, 16'd7);
    run(6'd63, 6'd2, 1'b0, cyc, nd, res);
    chk("wrap_result", res, 16'd12);

    for (int i = 0; i < 64; i++) wr(6'(i), 16'd1);
    run(6'd5, 6'd0, 1'b0, cyc, nd, res);
    chk("len0_result", res, 16'd64);
    chk("len0_cycles", cyc, 128);
    chk("len0_dones", nd, 1);

    @(negedge c);
    we = 1'b1; addr = 6'd9; din = 16'd42;
    start = 1'b1; base = 6'd9; len = 6'd1;
    @(negedge c);
    we = 1'b0; start = 1'b0;
    @(negedge c);
    @(negedge c);
    chk("samecyc_done", done, 1);
    chk("samecyc_result", result, 16'd42);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
